bit_serializer: RTL and testbench
=================================

Name: bit_serializer

Overview:
- Parallel-to-serial front end for the sequence detectors (sd101_mealy and siblings).
- Accepts WIDTH-bit words on a valid/ready handshake and shifts them out one bit per clock on sout, which drives the detector's din directly.
- sout_valid qualifies each bit.
- Back-to-back words stream with no idle gap, so overlapping patterns that cross a word boundary (e.g. "10|1") reach the detector unbroken.

Parameters:
WIDTH, 8, bits per word (>=2)
MSB_FIRST, 1, 1 = shift data_in[WIDTH-1] first; 0 = data_in[0] first
IDLE_BIT, 0, value driven on sout while no word is being shifted

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
data_in  input  WIDTH  word to serialize; sampled only on accept
load_valid  input  1  upstream has a word on data_in
load_ready  output  1  serializer can accept a word this cycle
sout  output  1  serial bit stream, registered; connects to detector din
sout_valid  output  1  sout carries a data bit this cycle
busy  output  1  word in progress (state == SHIFT)
bit_idx  output  $clog2(WIDTH)  index of bit currently on sout (0 = first bit)
words_sent  output  8  count of completed words, wraps 255->0
PS_out  output  2  present state, debug (IDLE=00, SHIFT=01)

Behaviour:
- Reset (async, any time, including mid-word):
  - state=IDLE, shift register=0, bit_idx=0, words_sent=0, sout=IDLE_BIT, sout_valid=0, busy=0.
  - load_ready=1 from the first cycle after rst deasserts.
  - The partially shifted word is discarded and is not counted.
- Accept: occurs at a rising edge with load_valid && load_ready. data_in is loaded into the shift register, bit_idx<=0, state<=SHIFT.
- load_ready, combinational: (state==IDLE) || (state==SHIFT && bit_idx==WIDTH-1).
  - The serializer accepts a new word during the last bit of the current word.
- Latency: word accepted at edge N -> first bit on sout in the cycle after edge N; last bit in the cycle after edge N+WIDTH-1.
- SHIFT, each edge:
  - If bit_idx<WIDTH-1: advance the shift register by one position (direction per MSB_FIRST), bit_idx++.
  - If bit_idx==WIDTH-1 and an accept occurs: load the new word, bit_idx<=0, stay in SHIFT, words_sent++. sout_valid stays 1 with no bubble.
  - If bit_idx==WIDTH-1 and no accept: state<=IDLE, words_sent++, sout<=IDLE_BIT, sout_valid<=0.
- sout and sout_valid are registered outputs (flop-driven, no combinational path from data_in).
  - sout = shreg[WIDTH-1] if MSB_FIRST, else shreg[0].
  - In IDLE, sout=IDLE_BIT and sout_valid=0.
- load_valid while load_ready=0: ignored; nothing is loaded. Upstream must hold data_in and load_valid until accepted.
- data_in changes while not accepting: no effect on sout.
- words_sent: 8-bit, increments once per fully shifted word, wraps modulo 256. A word interrupted by reset is not counted.
- bit_idx holds at 0 in IDLE.
- No combinational path from load_valid to sout/sout_valid. load_ready depends only on state and bit_idx.

Test Plan:
- Single word: rst 2 cycles, then load 8'hA5 (MSB_FIRST=1) -> sout_valid=1 for 8 cycles, sout = 1,0,1,0,0,1,0,1; detector dout pulses on bit 3 and bit 8; afterwards sout=0, sout_valid=0, words_sent=1.
- Back-to-back: load_valid held with 8'hA5 then 8'h3C -> 16 consecutive valid bits 10100101 00111100 with no bubble; load_ready high only in IDLE and on bit_idx=7; words_sent=2.
- Load while busy: assert load_valid with 8'hFF at bit_idx=3 of 8'hA5 -> ignored until bit_idx=7, then accepted; the 8'hA5 stream is unaltered.
- Reset mid-word: assert rst at bit_idx=4 of 8'hA5 -> immediate sout=0, sout_valid=0, PS_out=00, words_sent=0; next word 8'h5A serializes correctly from bit 0.
- LSB-first, WIDTH=3, IDLE_BIT=1: load 3'b110 -> sout = 0,1,1, then idle at 1 with sout_valid=0; words_sent=1.
- Wrap: stream 256 words back-to-back -> words_sent returns to 0; the 257th completed word gives 1.

Source files
------------

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the sequence detectors.
// Accepts WIDTH-bit words on a valid/ready handshake and shifts them out one
// bit per clock on sout (qualified by sout_valid). A new word can be taken
// during the last bit of the current one, so consecutive words stream with no
// idle gap and patterns crossing a word boundary reach the detector intact.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     load_valid,
  output logic                     load_ready,
  output logic                     sout,
  output logic                     sout_valid,
  output logic                     busy,
  output logic [$clog2(WIDTH)-1:0] bit_idx,
  output logic [7:0]               words_sent,
  output logic [1:0]               PS_out
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [7:0]       words_q, words_d;
  logic             sout_q, sout_d;
  logic             sv_q, sv_d;
  logic             accept;

  // The bit that goes out first from a given shift-register value.
  function automatic logic head_bit(input logic [WIDTH-1:0] s);
    return MSB_FIRST ? s[WIDTH-1] : s[0];
  endfunction

  // Move the next bit into the head position.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    return MSB_FIRST ? {s[WIDTH-2:0], 1'b0} : {1'b0, s[WIDTH-1:1]};
  endfunction

  // Ready depends only on state and position, never on load_valid.
  assign load_ready = (state_q == S_IDLE) ||
                      ((state_q == S_SHIFT) && (idx_q == LAST_IDX));
  assign accept     = load_valid && load_ready;

  // Next-state, shift and counter logic; sout is precomputed from the next
  // shift-register value so the output stays a plain flop.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    words_d = words_q;
    case (state_q)
      S_IDLE: begin
        idx_d = '0;
        if (accept) begin
          shreg_d = data_in;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (idx_q != LAST_IDX) begin
          shreg_d = advance(shreg_q);
          idx_d   = idx_q + 1'b1;
        end else begin
          // Last bit leaves the line on this edge: the word is complete.
          words_d = words_q + 8'd1;
          idx_d   = '0;
          if (accept) begin
            shreg_d = data_in;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
    sout_d = (state_d == S_SHIFT) ? head_bit(shreg_d) : IDLE_BIT;
    sv_d   = (state_d == S_SHIFT);
  end

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      words_q <= 8'd0;
      sout_q  <= IDLE_BIT;
      sv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      words_q <= words_d;
      sout_q  <= sout_d;
      sv_q    <= sv_d;
    end
  end

  assign sout       = sout_q;
  assign sout_valid = sv_q;
  assign busy       = (state_q == S_SHIFT);
  assign bit_idx    = idx_q;
  assign words_sent = words_q;
  assign PS_out     = state_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: a queue-based reference model of the serial
// stream checked every cycle, plus literal expectations per scenario.
module tb_bit_serializer;
  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  // Main instance: WIDTH=8, MSB first, idle low
  logic [7:0] data_in    = 8'd0;
  logic       load_valid = 1'b0;
  logic       load_ready, sout, sout_valid, busy;
  logic [2:0] bit_idx;
  logic [7:0] words_sent;
  logic [1:0] PS_out;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .sout(sout), .sout_valid(sout_valid), .busy(busy),
    .bit_idx(bit_idx), .words_sent(words_sent), .PS_out(PS_out));

  // Second instance: WIDTH=3, LSB first, idle high
  logic [2:0] din2 = 3'd0;
  logic       lv2  = 1'b0;
  logic       lr2, so2, sv2, busy2;
  logic [1:0] idx2;
  logic [7:0] ws2;
  logic [1:0] ps2;

  bit_serializer #(.WIDTH(3), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut2 (
    .clk(clk), .rst(rst), .data_in(din2), .load_valid(lv2),
    .load_ready(lr2), .sout(so2), .sout_valid(sv2), .busy(busy2),
    .bit_idx(idx2), .words_sent(ws2), .PS_out(ps2));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of bits still to appear after the current one.
  bit mq[$];
  bit m_valid    = 1'b0;
  bit m_sout     = 1'b0;
  bit m_accepted = 1'b0;
  int m_idx      = 0;
  int m_words    = 0;

  function automatic bit m_ready();
    return !m_valid || (mq.size() == 0);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_valid = 1'b0; m_sout = 1'b0; m_idx = 0; m_words = 0; m_accepted = 1'b0;
    end else begin
      m_accepted = load_valid && m_ready();
      if (m_valid && mq.size() == 0) m_words = (m_words + 1) % 256;
      if (m_accepted)
        for (int i = W - 1; i >= 0; i--) mq.push_back(data_in[i]);
      if (mq.size() > 0) begin
        m_sout  = mq.pop_front();
        m_valid = 1'b1;
        m_idx   = W - 1 - mq.size();
      end else begin
        m_valid = 1'b0; m_sout = 1'b0; m_idx = 0;
      end
    end
  end

  // Observed serial streams
  bit seen[$];
  bit seen2[$];

  function automatic int seen_val();
    int v = 0;
    foreach (seen[i]) v = (v << 1) | int'(seen[i]);
    return v;
  endfunction

  function automatic int seen2_val();
    int v = 0;
    foreach (seen2[i]) v = (v << 1) | int'(seen2[i]);
    return v;
  endfunction

  // Per-cycle compare of the main instance against the model
  always @(negedge clk) begin
    chk("sout",       int'(sout),       int'(m_sout));
    chk("sout_valid", int'(sout_valid), int'(m_valid));
    chk("busy",       int'(busy),       int'(m_valid));
    chk("load_ready", int'(load_ready), int'(m_ready()));
    chk("bit_idx",    int'(bit_idx),    m_idx);
    chk("words_sent", int'(words_sent), m_words);
    chk("PS_out",     int'(PS_out),     m_valid ? 1 : 0);
    if (sout_valid) seen.push_back(sout);
    if (sv2) seen2.push_back(so2);
  end

  task automatic push_word(input logic [7:0] w);
    int t = 0;
    load_valid = 1'b1;
    data_in    = w;
    do begin @(posedge clk); #1; t++; end while (!m_accepted && t < 40);
    if (!m_accepted) chk("accept_timeout", int'(m_accepted), 1);
    load_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (m_valid && t < 40) begin @(posedge clk); #1; t++; end
    if (m_valid) chk("idle_timeout", int'(m_valid), 0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1 pulse_reset();
    chk("rst_sout",   int'(sout),       0);
    chk("rst_valid",  int'(sout_valid), 0);
    chk("rst_words",  int'(words_sent), 0);
    chk("rst_ready",  int'(load_ready), 1);
    chk("rst_sout2",  int'(so2),        1);

    // Single word
    seen.delete();
    push_word(8'hA5);
    wait_idle();
    chk("single_len",   seen.size(),      8);
    chk("single_bits",  seen_val(),       'hA5);
    chk("single_words", int'(words_sent), 1);
    chk("single_model_words", m_words,    1);
    chk("single_idle_sout", int'(sout),   0);
    $display("single word A5: bits=%0h words=%0d", seen_val(), words_sent);

    // Back-to-back words
    seen.delete();
    push_word(8'hA5);
    push_word(8'h3C);
    wait_idle();
    chk("b2b_len",   seen.size(),      16);
    chk("b2b_bits",  seen_val(),       'hA53C);
    chk("b2b_words", int'(words_sent), 3);
    $display("back-to-back A5,3C: bits=%0h words=%0d", seen_val(), words_sent);

    // Load while busy
    seen.delete();
    push_word(8'hA5);
    repeat (3) begin @(posedge clk); #1; end
    chk("busy_idx3", int'(bit_idx), 3);
    push_word(8'hFF);
    wait_idle();
    chk("busy_len",  seen.size(),      16);
    chk("busy_bits", seen_val(),       'hA5FF);
    chk("busy_words", int'(words_sent), 5);
    $display("load while busy A5,FF: bits=%0h words=%0d", seen_val(), words_sent);

    // Reset mid-word
    push_word(8'hA5);
    repeat (4) begin @(posedge clk); #1; end
    chk("midrst_idx4", int'(bit_idx), 4);
    #2 rst = 1'b1;
    #1;
    chk("midrst_sout",  int'(sout),       0);
    chk("midrst_valid", int'(sout_valid), 0);
    chk("midrst_ps",    int'(PS_out),     0);
    chk("midrst_words", int'(words_sent), 0);
    @(posedge clk); #1 rst = 1'b0;
    seen.delete();
    push_word(8'h5A);
    wait_idle();
    chk("midrst_len",   seen.size(),      8);
    chk("midrst_bits",  seen_val(),       'h5A);
    chk("midrst_after_words", int'(words_sent), 1);
    $display("reset mid-word then 5A: bits=%0h words=%0d", seen_val(), words_sent);

    // LSB-first, WIDTH=3, IDLE_BIT=1 instance
    seen2.delete();
    din2 = 3'b110;
    lv2  = 1'b1;
    @(posedge clk); #1 lv2 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("lsb_len",   seen2.size(), 3);
    chk("lsb_bits",  seen2_val(),  3);   // sequence 0,1,1
    chk("lsb_sout",  int'(so2),    1);
    chk("lsb_valid", int'(sv2),    0);
    chk("lsb_words", int'(ws2),    1);
    $display("lsb-first 110: bits=%0b words=%0d", seen2_val(), ws2);

    // Wrap of words_sent
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      push_word(8'(i));
      if (i % 64 == 0) seen.delete();
    end
    wait_idle();
    chk("wrap_256", int'(words_sent), 0);
    push_word(8'h81);
    wait_idle();
    chk("wrap_257", int'(words_sent), 1);
    $display("wrap: after 257 words words_sent=%0d", words_sent);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
